// File: rtl/period_meter_pkg.sv
// Shared types and default sizing for the period meter.
package period_meter_pkg;

    localparam int unsigned DEF_CNT_WIDTH   = 16;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

endpackage

// File: rtl/period_meter_sync_edge_detect.sv
// Brings sig_in into the clk domain and flags its rising and falling edges.
module sync_edge_detect
    import period_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic sig_s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            sig_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            sig_d  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sig_s = sync_q[SYNC_STAGES-1];
    assign rise  = sig_s & ~sig_d;
    assign fall  = ~sig_s & sig_d;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow input in clk cycles, with stall timeout.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sig_in,
    output logic [CNT_WIDTH-1:0] period_out,
    output logic [CNT_WIDTH-1:0] high_out,
    output logic                 period_valid,
    output logic                 timeout
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t               state, state_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;
    logic [CNT_WIDTH-1:0] hcap, hcap_n;
    logic [CNT_WIDTH-1:0] period_n, high_n;
    logic                 valid_n, timeout_n;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 rise, fall;
    logic                 sync_level_unused;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .sig_s  (sync_level_unused),
        .rise   (rise),
        .fall   (fall)
    );

    // A full-scale count of 2^CNT_WIDTH truncates to 0 here by design.
    assign cnt_inc = cnt + CNT_WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            hcap         <= '0;
            period_out   <= '0;
            high_out     <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            hcap         <= hcap_n;
            period_out   <= period_n;
            high_out     <= high_n;
            period_valid <= valid_n;
            timeout      <= timeout_n;
        end
    end

    // Next-state: en drop wins over rise, rise wins over the stall check.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        hcap_n    = hcap;
        period_n  = period_out;
        high_n    = high_out;
        valid_n   = 1'b0;
        timeout_n = timeout;

        case (state)
            IDLE: begin
                if (rise) begin
                    cnt_n = '0;
                end
                if (en && rise) begin
                    state_n   = MEASURE;
                    timeout_n = 1'b0;
                end
            end
            MEASURE: begin
                if (rise) begin
                    cnt_n = '0;
                end
                if (!en) begin
                    state_n = IDLE;
                end else if (rise) begin
                    period_n = cnt_inc;
                    high_n   = hcap;
                    valid_n  = 1'b1;
                end else begin
                    if (fall) begin
                        hcap_n = cnt_inc;
                    end
                    if (cnt == CNT_MAX) begin
                        timeout_n = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_period_meter.sv
// Randomised and directed bench for period_meter against an event-time model.
module tb_period_meter;

    localparam int unsigned CW   = 8;
    localparam int unsigned SS   = 2;
    localparam int          FULL = 1 << CW;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          sig_in;
    logic [CW-1:0] period_out;
    logic [CW-1:0] high_out;
    logic          period_valid;
    logic          timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pulse = 0;

    period_meter #(
        .CNT_WIDTH   (CW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sig_in       (sig_in),
        .period_out   (period_out),
        .high_out     (high_out),
        .period_valid (period_valid),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: rises/falls are the sampled input delayed by the synchroniser depth;
    // period and high time are differences between edge timestamps.
    logic [SS:0]   hist = '0;
    logic          m_active = 1'b0;
    int            cyc = 0;
    int            last_rise = 0;
    logic [CW-1:0] hval = '0;
    logic [CW-1:0] exp_period = '0;
    logic [CW-1:0] exp_high = '0;
    logic          exp_valid = 1'b0;
    logic          exp_timeout = 1'b0;

    always @(posedge clk) begin
        logic m_rise, m_fall;
        int   age;
        cyc++;
        if (rst) begin
            hist        = '0;
            m_active    = 1'b0;
            hval        = '0;
            exp_period  = '0;
            exp_high    = '0;
            exp_valid   = 1'b0;
            exp_timeout = 1'b0;
        end else begin
            m_rise    = hist[SS-1] & ~hist[SS];
            m_fall    = ~hist[SS-1] & hist[SS];
            age       = cyc - last_rise;
            exp_valid = 1'b0;
            if (!m_active) begin
                if (en && m_rise) begin
                    m_active    = 1'b1;
                    last_rise   = cyc;
                    exp_timeout = 1'b0;
                end
            end else if (!en) begin
                m_active = 1'b0;
            end else if (m_rise) begin
                exp_valid  = 1'b1;
                exp_period = CW'(age);
                exp_high   = hval;
                last_rise  = cyc;
            end else begin
                if (m_fall) hval = CW'(age);
                if (age == FULL) begin
                    exp_timeout = 1'b1;
                    m_active    = 1'b0;
                end
            end
            hist = {hist[SS-1:0], sig_in};
        end
        #1;
        check("period_valid", int'(period_valid), int'(exp_valid));
        check("timeout", int'(timeout), int'(exp_timeout));
        check("period_out", int'(period_out), int'(exp_period));
        check("high_out", int'(high_out), int'(exp_high));
        if (period_valid) n_pulse++;
    end

    // Drivers assume they start at a negedge and leave at one.
    task automatic drive(input logic s, input int n);
        sig_in = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        repeat (n) begin
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
    endtask

    initial begin
        int hi, lo, p0;
        rst    = 1'b1;
        en     = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_period", int'(period_out), 0);
        check("reset_valid", int'(period_valid), 0);
        check("reset_timeout", int'(timeout), 0);

        rst = 1'b0;
        en  = 1'b1;
        drive(1'b0, 100);
        check("static_pulses", n_pulse, 0);
        check("static_period", int'(period_out), 0);
        check("static_high", int'(high_out), 0);

        wave(2, 2, 10);
        check("div4_period", int'(period_out), 4);
        check("div4_high", int'(high_out), 2);

        wave(5, 5, 6);
        check("div10_period", int'(period_out), 10);
        check("div10_high", int'(high_out), 5);
        wave(3, 3, 6);
        check("div6_period", int'(period_out), 6);
        check("div6_high", int'(high_out), 3);

        wave(1, 1, 8);
        check("min_period", int'(period_out), 2);
        check("min_high", int'(high_out), 1);

        wave(3, 3, 3);
        drive(1'b0, 300);
        check("stall_timeout", int'(timeout), 1);
        wave(4, 4, 4);
        check("restart_timeout", int'(timeout), 0);
        check("restart_period", int'(period_out), 8);
        check("restart_high", int'(high_out), 4);

        wave(100, 156, 3);
        check("full_scale_period", int'(period_out), 0);
        check("full_scale_high", int'(high_out), 100);
        check("full_scale_timeout", int'(timeout), 0);

        wave(5, 5, 4);
        drive(1'b1, 2);
        en = 1'b0;
        drive(1'b1, 3);
        en = 1'b1;
        drive(1'b0, 5);
        check("en_drop_hold_period", int'(period_out), 10);
        check("en_drop_hold_high", int'(high_out), 5);
        p0 = n_pulse;
        wave(5, 5, 1);
        check("en_drop_no_pulse", n_pulse - p0, 0);
        wave(5, 5, 3);

        drive(1'b1, 2);
        rst = 1'b1;
        drive(1'b1, 2);
        check("rst_mid_period", int'(period_out), 0);
        check("rst_mid_high", int'(high_out), 0);
        rst = 1'b0;
        drive(1'b0, 5);
        wave(4, 3, 4);

        // Random periods with occasional enable drops and resets.
        repeat (60) begin
            hi = int'($urandom_range(1, 12));
            lo = int'($urandom_range(1, 12));
            if ($urandom_range(0, 9) == 0) begin
                en = 1'b0;
                drive(sig_in, int'($urandom_range(1, 4)));
                en = 1'b1;
            end
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1;
                drive(sig_in, 2);
                rst = 1'b0;
            end
            wave(hi, lo, int'($urandom_range(1, 3)));
        end
        drive(1'b0, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures a slow, clock-like input such as a prescaled clock or an external square wave.
- Synchronises the input into the system clock domain and detects its edges.
- Reports, once per input period, the period and the high time, both in system-clock cycles.
- Raises a timeout flag when the input stalls.
- Used on-chip as a self-check of divided clocks and to measure externally supplied rate signals.

Parameters:
- CNT_WIDTH, 16, width of the cycle counter and of the period/high-time outputs (min 4).
- SYNC_STAGES, 2, number of synchroniser flops on sig_in (min 2).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  measurement enable, synchronous to clk.
- sig_in  input  1  signal to be measured, asynchronous to clk.
- period_out  output  CNT_WIDTH  cycles between the last two detected rising edges.
- high_out  output  CNT_WIDTH  cycles from the latest detected rising edge to the following detected falling edge.
- period_valid  output  1  one-cycle pulse when period_out/high_out update.
- timeout  output  1  level; input stalled.

Behaviour:
- Reset: all synchroniser flops, edge register, counter, period_out, high_out, period_valid and timeout go to 0; state goes to IDLE.
- Synchroniser: sig_in passes through SYNC_STAGES flops to give sig_s. A further register holds sig_d.
  - rise = sig_s & ~sig_d.
  - fall = ~sig_s & sig_d.
  - A change on sig_in is detected SYNC_STAGES+1 clk cycles later.
- Counter cnt, CNT_WIDTH bits:
  - Cleared to 0 on every cycle with rise in IDLE or MEASURE.
  - Otherwise increments in MEASURE.
  - Holds in IDLE.
  - Never wraps; it saturates at MAX = 2^CNT_WIDTH-1.
- States:
  - IDLE: waiting for the first rising edge.
    - en=1 & rise -> MEASURE; cnt<=0; timeout<=0; no valid pulse.
    - fall is ignored.
  - MEASURE: counting.
    - rise -> period_out<=cnt+1; high_out<=hcap; period_valid<=1 (next cycle only); cnt<=0; stay in MEASURE.
    - fall -> hcap<=cnt+1. hcap is an internal register, reset 0.
    - no rise & cnt==MAX -> timeout<=1; go to IDLE.
    - en=0 -> go to IDLE; no pulse; outputs hold.
- Priority within one cycle: en=0 beats rise, and rise beats the timeout check.
  - A rise when cnt==MAX produces a valid period of 2^CNT_WIDTH with no timeout.
- Registered outputs: period_out, high_out and period_valid update on the clock edge that ends the rise cycle, so period_valid is high in the cycle after the rise cycle.
  - period_out and high_out hold their values until the next update.
- timeout:
  - Asserted 2^CNT_WIDTH cycles after the last detected rise when no further rise arrives.
  - Cleared by the next rise accepted in IDLE, or by reset.
- Limits: the minimum measurable period is 2 cycles (sig_in toggling every clk); this yields period 2, high 1.
- Arithmetic: cnt+1 is computed in CNT_WIDTH+1 bits and truncated.
  - Only a period of 2^CNT_WIDTH truncates, and it reads as 0.
  - period_out == 0 after a valid pulse therefore means "full scale".
- Reset mid-measurement: the block returns to IDLE at once and the partial count is discarded.

Decomposition:
- Shared package period_meter_pkg holds:
  - the state enum (IDLE, MEASURE);
  - default constants DEF_CNT_WIDTH=16 and DEF_SYNC_STAGES=2.
- One sub-module, sync_edge_detect, parameterised by SYNC_STAGES:
  - input: sig_in;
  - outputs: sig_s, rise, fall;
  - reset: asynchronous, active-high.
- The top level holds the FSM, cnt, hcap and the output registers.

Test Plan:
- Reset held, then released with en=1 and sig_in static low for 100 cycles -> all outputs remain 0; no period_valid.
- sig_in from a divide-by-4 clock source (toggling every 2 clk), en=1 -> first rise gives no pulse; every subsequent rise gives one period_valid pulse with period_out=4 and high_out=2, repeating every 4 cycles.
- Divide-by-10 source, then switched to divide-by-6 mid-run -> pulses report 10/5, then 6/3 from the second rise after the switch; no pulse ever reports an intermediate value other than the transition period.
- CNT_WIDTH=8, source stopped low after a rise -> timeout=1 exactly 256 cycles after that rise cycle, with no pulse; restarting the source -> timeout=0 at the first rise, and the next valid pulse carries the correct period.
- CNT_WIDTH=8, a rise arriving exactly when cnt==255 -> period_valid=1 with period_out=0 (full scale 256) and timeout stays 0.
- en dropped for 3 cycles mid-period, or rst pulsed mid-period -> no period_valid until two new rises have been seen; outputs hold after en drop and are 0 after rst.
